deck_card_server: RTL and testbench

Card-source side of the card request handshake used by the player, flop and single-card deal controllers. It holds a 52-card deck as a dealt-card mask and answers each next_card request with one undealt card on card/card_valid. Draws are without replacement until new_hand reshuffles the deck. It sits between the game controller and the deal controllers.

---
 rtl/deck_card_server.sv | 129 ++++++++++++
 tb/tb_deck_card_server.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/deck_card_server.sv
// deck_card_server: 52-card deck with dealt mask, LFSR start point,
// and a next_card / card_valid request handshake toward deal controllers.
module deck_card_server #(
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter bit          SEQUENTIAL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       next_card,
    input  logic       new_hand,
    output logic [5:0] card,
    output logic       card_valid,
    output logic [5:0] cards_remaining,
    output logic       deck_empty
);

    localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEARCH  = 2'd1,
        PRESENT = 2'd2
    } state_t;

    state_t      state;
    state_t      state_d;
    logic [15:0] lfsr;
    logic [51:0] dealt;
    logic [1:0]  suit;
    logic [3:0]  rank;
    logic [5:0]  idx;
    logic [3:0]  lfsr_rank;
    logic        load;
    logic        hit;
    logic        step;

    // rank folded into 0..12 without a divider
    assign lfsr_rank = (lfsr[3:0] > 4'd12) ? (lfsr[3:0] - 4'd13) : lfsr[3:0];

    // mask slot = suit*13 + rank, built from shifts and adds
    assign idx = ({4'b0, suit} << 3) + ({4'b0, suit} << 2)
               + {4'b0, suit} + {2'b0, rank};

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_d;
    end

    // next-state and datapath strobes; new_hand overrides every state
    always_comb begin
        state_d = state;
        load    = 1'b0;
        hit     = 1'b0;
        step    = 1'b0;
        if (new_hand) begin
            state_d = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (next_card && !deck_empty) begin
                        load    = 1'b1;
                        state_d = SEARCH;
                    end
                end
                SEARCH: begin
                    if (!dealt[idx]) begin
                        hit     = 1'b1;
                        state_d = PRESENT;
                    end else begin
                        step = 1'b1;
                    end
                end
                PRESENT: begin
                    if (!next_card) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // free-running Fibonacci LFSR, taps 16,14,13,11
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr <= SEED;
        else      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    // search pointer: loaded on request, stepped over dealt slots
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            suit <= 2'd0;
            rank <= 4'd0;
        end else if (load) begin
            suit <= SEQUENTIAL ? 2'd0 : lfsr[5:4];
            rank <= SEQUENTIAL ? 4'd0 : lfsr_rank;
        end else if (step) begin
            if (rank == 4'd12) begin
                rank <= 4'd0;
                suit <= suit + 2'd1;
            end else begin
                rank <= rank + 4'd1;
            end
        end
    end

    // deck mask, counters and the presented card
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dealt           <= '0;
            card            <= 6'd0;
            card_valid      <= 1'b0;
            cards_remaining <= 6'd52;
            deck_empty      <= 1'b0;
        end else begin
            card_valid <= (state_d == PRESENT);
            if (new_hand) begin
                dealt           <= '0;
                cards_remaining <= 6'd52;
                deck_empty      <= 1'b0;
            end else if (hit) begin
                card            <= {suit, rank};
                dealt[idx]      <= 1'b1;
                cards_remaining <= cards_remaining - 6'd1;
                deck_empty      <= (cards_remaining == 6'd1);
            end
        end
    end

endmodule

// File: tb/tb_deck_card_server.sv
// tb_deck_card_server: sequential-order vector table plus a randomized
// full-deck deal checked against a set-of-cards model.
module tb_deck_card_server;

    logic       clk;
    logic       rst;
    logic       nc_s, nh_s, nc_r, nh_r;
    logic [5:0] card_s, card_r, rem_s, rem_r;
    logic       cv_s, cv_r, emp_s, emp_r;

    bit         sel;
    int         checks;
    int         errors;

    typedef struct {
        logic [5:0] card;
        int         lat;
        int         rem;
    } vec_t;

    vec_t vec[14];

    deck_card_server #(.LFSR_SEED(16'hACE1), .SEQUENTIAL(1'b1)) u_seq (
        .clk(clk), .rst(rst), .next_card(nc_s), .new_hand(nh_s),
        .card(card_s), .card_valid(cv_s),
        .cards_remaining(rem_s), .deck_empty(emp_s)
    );

    deck_card_server #(.LFSR_SEED(16'h5A3C), .SEQUENTIAL(1'b0)) u_rnd (
        .clk(clk), .rst(rst), .next_card(nc_r), .new_hand(nh_r),
        .card(card_r), .card_valid(cv_r),
        .cards_remaining(rem_r), .deck_empty(emp_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic cv_m();
        return sel ? cv_r : cv_s;
    endfunction

    function automatic logic [5:0] card_m();
        return sel ? card_r : card_s;
    endfunction

    function automatic int rem_m();
        return sel ? int'(rem_r) : int'(rem_s);
    endfunction

    function automatic int emp_m();
        return sel ? int'(emp_r) : int'(emp_s);
    endfunction

    task automatic set_nc(input logic v);
        if (sel) nc_r = v;
        else     nc_s = v;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // called at a negedge; returns the card once card_valid is seen
    task automatic request(output logic [5:0] c, output int lat);
        bit ok;
        ok  = 1'b0;
        lat = 0;
        set_nc(1'b1);
        for (int i = 0; i < 60 && !ok; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (cv_m()) ok = 1'b1;
        end
        if (!ok) lat = 999;
        c = card_m();
    endtask

    // hold next_card for extra cycles checking stability, then drop
    task automatic release_req(input int hold, input logic [5:0] c);
        int bad;
        bad = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!cv_m() || card_m() != c) bad++;
        end
        if (hold > 0) chk("hold_stable", bad, 0);
        set_nc(1'b0);
        @(negedge clk);
        chk("valid_drop", int'(cv_m()), 0);
    endtask

    task automatic pulse_new_hand();
        if (sel) nh_r = 1'b1;
        else     nh_s = 1'b1;
        @(negedge clk);
        nh_r = 1'b0;
        nh_s = 1'b0;
    endtask

    logic [5:0] c;
    int         lat;
    bit         seen[64];
    int         dealt_n;
    int         bad;

    initial begin
        checks = 0;
        errors = 0;
        sel    = 1'b0;
        nc_s = 1'b0; nh_s = 1'b0; nc_r = 1'b0; nh_r = 1'b0;

        for (int i = 0; i < 14; i++) begin
            vec[i].card = {2'(i / 13), 4'(i % 13)};
            vec[i].lat  = i + 2;
            vec[i].rem  = 51 - i;
        end

        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_card", int'(card_s), 0);
        chk("rst_valid", int'(cv_s), 0);
        chk("rst_rem", int'(rem_s), 52);
        chk("rst_empty", int'(emp_s), 0);
        rst = 1'b1;
        @(negedge clk);

        // sequential order table: card, latency, remaining
        for (int i = 0; i < 14; i++) begin
            request(c, lat);
            chk($sformatf("seq_card%0d", i), int'(c), int'(vec[i].card));
            chk($sformatf("seq_lat%0d", i), lat, vec[i].lat);
            chk($sformatf("seq_rem%0d", i), int'(rem_s), vec[i].rem);
            release_req(0, c);
        end

        // held request: 15th card, held 10 cycles
        request(c, lat);
        chk("hold_card", int'(c), 6'h11);
        chk("hold_lat", lat, 16);
        release_req(10, c);
        chk("hold_rem", int'(rem_s), 37);

        // new_hand while presenting with 40 cards left
        pulse_new_hand();
        chk("nh_rem", int'(rem_s), 52);
        for (int i = 0; i < 11; i++) begin
            request(c, lat);
            release_req(0, c);
        end
        request(c, lat);
        chk("pre_nh_card", int'(c), 6'h0B);
        chk("pre_nh_rem", int'(rem_s), 40);
        nh_s = 1'b1;
        @(negedge clk);
        nh_s = 1'b0;
        chk("nh_valid", int'(cv_s), 0);
        chk("nh_rem52", int'(rem_s), 52);
        request(c, lat);
        chk("reserve_card", int'(c), 6'h00);
        chk("reserve_lat", lat, 2);
        chk("reserve_rem", int'(rem_s), 51);
        release_req(0, c);

        // player deal of four then a three-card flop
        pulse_new_hand();
        for (int i = 0; i < 7; i++) begin
            request(c, lat);
            chk($sformatf("deal_card%0d", i), int'(c), i);
            release_req(i == 3 ? 2 : 0, c);
        end
        chk("deal_rem", int'(rem_s), 45);

        // reset in the middle of a search
        set_nc(1'b1);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("midrst_valid", int'(cv_s), 0);
        chk("midrst_rem", int'(rem_s), 52);
        chk("midrst_card", int'(card_s), 0);
        set_nc(1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // random mode: 52 distinct cards against a seen-set model
        sel = 1'b1;
        repeat ($urandom_range(1, 20)) @(negedge clk);
        foreach (seen[i]) seen[i] = 1'b0;
        dealt_n = 0;
        for (int i = 0; i < 52; i++) begin
            request(c, lat);
            if (lat < 2 || lat > 53) chk("rnd_lat", lat, 53);
            if (c[3:0] > 4'd12) chk("rnd_rank", int'(c[3:0]), 12);
            if (seen[c]) chk("rnd_dup", int'(c), -1);
            seen[c] = 1'b1;
            dealt_n++;
            if (rem_m() != 52 - dealt_n) chk("rnd_rem", rem_m(), 52 - dealt_n);
            release_req(int'($urandom_range(0, 3)), c);
        end
        bad = 0;
        foreach (seen[i]) if (seen[i]) bad++;
        chk("rnd_distinct", bad, 52);
        chk("rnd_rem0", rem_m(), 0);
        chk("rnd_empty", emp_m(), 1);

        // empty deck: request must never be answered
        set_nc(1'b1);
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cv_m()) bad++;
        end
        chk("empty_no_valid", bad, 0);
        set_nc(1'b0);
        @(negedge clk);

        pulse_new_hand();
        chk("rnd_nh_rem", rem_m(), 52);
        chk("rnd_nh_empty", emp_m(), 0);
        request(c, lat);
        if (c[3:0] > 4'd12) chk("rnd2_rank", int'(c[3:0]), 12);
        chk("rnd2_rem", rem_m(), 51);
        release_req(1, c);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
